// File: rtl/gray_pkg.sv
// gray_pkg: shared Gray-code helpers for the converter, gray_counter and
// pointer-sync blocks.
//   GRAY_WIDTH_DEF : default counter width
//   GRAY_MAX_W     : widest vector the helpers handle
//   bin2gray/gray2bin operate on GRAY_MAX_W-bit vectors. Callers zero-extend
//   a narrower value and truncate the result. Zero upper bits do not disturb
//   the low bits of either transform.
package gray_pkg;

    localparam int GRAY_WIDTH_DEF = 4;
    localparam int GRAY_MAX_W     = 32;

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of the Gray bits at and above its position.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--)
            b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

endpackage

// File: rtl/gray_to_bin.sv
// gray_to_bin: combinational Gray-to-binary decoder.
//   WIDTH          : vector width
//   gray [WIDTH]   : Gray-coded input
//   bin  [WIDTH]   : binary result; the msb passes straight through
// Each output bit is the parity of the Gray bits from that position upward.
// Computing each bit independently avoids a bit-to-bit ripple chain through
// the same vector.
module gray_to_bin #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bin[i] = ^(gray >> i);
    end

endmodule

// File: rtl/gray_counter.sv
// gray_counter: registered up/down Gray-code counter with load, clear and
// wrap flag.
//   WIDTH (2..32)     : counter width
//   clk, rst_n        : clock; synchronous active-low reset
//   en, up            : step by one, with direction (1 = up)
//   load, load_val    : synchronous load of a binary value
//   clr               : synchronous clear
//   bin_out, gray_out : registered binary and Gray counts
//   tc                : one-cycle pulse after a counting wrap
//   gray_in, dec_out  : registered Gray decode, present only when the
//                       GRAY_COUNTER_DECODE_EN macro is defined
// Per-edge priority is rst_n, then clr, then load, then en.
module gray_counter
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
`ifdef GRAY_COUNTER_DECODE_EN
    input  logic [WIDTH-1:0] gray_in,
    output logic [WIDTH-1:0] dec_out,
`endif
    output logic             tc
);

    logic [WIDTH-1:0] cnt_nxt;
    logic             tc_nxt;

    always_comb begin
        cnt_nxt = bin_out;
        tc_nxt  = 1'b0;
        if (clr) begin
            cnt_nxt = '0;
        end else if (load) begin
            cnt_nxt = load_val;
        end else if (en) begin
            if (up) begin
                cnt_nxt = bin_out + WIDTH'(1);
                tc_nxt  = &bin_out;
            end else begin
                cnt_nxt = bin_out - WIDTH'(1);
                tc_nxt  = ~|bin_out;
            end
        end
    end

    // gray_out is registered from the next count, so it never glitches
    // through a combinational decode of bin_out.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bin_out  <= '0;
            gray_out <= '0;
            tc       <= 1'b0;
        end else begin
            bin_out  <= cnt_nxt;
            gray_out <= WIDTH'(bin2gray(GRAY_MAX_W'(cnt_nxt)));
            tc       <= tc_nxt;
        end
    end

`ifdef GRAY_COUNTER_DECODE_EN
    logic [WIDTH-1:0] dec_nxt;

    gray_to_bin #(.WIDTH(WIDTH)) u_dec (
        .gray (gray_in),
        .bin  (dec_nxt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) dec_out <= '0;
        else        dec_out <= dec_nxt;
    end
`endif

endmodule
